mem_stage_ws: RTL and testbench

Pipelined memory-access stage with a full bus handshake. Loads and stores hold the bus until acknowledge and stall upstream while waiting. Byte, halfword and word accesses use big-endian lane steering, loads can be sign- or zero-extended, and misaligned accesses, bus errors and bus timeouts raise exceptions. Sits between execute and writeback; non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_stage_ws_pkg.sv | 33 +++
 rtl/mem_stage_ws_if.sv | 28 ++
 rtl/mem_stage_ws_lane_steer.sv | 101 ++++++++++
 rtl/mem_stage_ws.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_stage_ws.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_ws_pkg.sv
// mem_stage_ws_pkg: shared types and constants for the memory-access stage.
//   T_LOAD/T_STORE   instruction type codes (ir[31:28])
//   size_t           access size from op[1:0]
//   mem_state_t      access state machine states
//   EXC_*            exception codes carried with the retiring instruction
package mem_stage_ws_pkg;

  localparam logic [3:0] T_LOAD  = 4'h8;
  localparam logic [3:0] T_STORE = 4'h9;

  typedef enum logic [1:0] {
    SZ_WORD  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_BYTE  = 2'd2,
    SZ_DWORD = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  localparam logic [3:0] EXC_NONE  = 4'd0;
  localparam logic [3:0] EXC_ALIGN = 4'd1;
  localparam logic [3:0] EXC_BUS   = 4'd2;

  // True for instruction types that touch the data bus.
  function automatic logic is_mem_op(input logic [3:0] itype);
    return (itype == T_LOAD) || (itype == T_STORE);
  endfunction

endpackage

// File: rtl/mem_stage_ws_if.sv
// mem_stage_ws_if: data-bus handshake between the memory stage (master)
// and memory/peripherals (slave).
//   bus_adr/bus_cyc/bus_stb/bus_we/bus_sel/bus_out  master -> slave
//   bus_in/bus_ack/bus_err                          slave -> master
interface mem_stage_ws_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   bus_adr;
  logic            bus_cyc;
  logic            bus_stb;
  logic            bus_we;
  logic [DW/8-1:0] bus_sel;
  logic [DW-1:0]   bus_out;
  logic [DW-1:0]   bus_in;
  logic            bus_ack;
  logic            bus_err;

  modport master (
    output bus_adr, bus_cyc, bus_stb, bus_we, bus_sel, bus_out,
    input  bus_in, bus_ack, bus_err
  );

  modport slave (
    input  bus_adr, bus_cyc, bus_stb, bus_we, bus_sel, bus_out,
    output bus_in, bus_ack, bus_err
  );
endinterface

// File: rtl/mem_stage_ws_lane_steer.sv
// mem_lane_steer: combinational big-endian byte-lane steering.
//   i_adr_lo   low address bits of the access
//   i_size     access size, i_sign sign-extend byte/half loads
//   i_wdata    store data (right-aligned), i_rdata raw bus read data
//   o_sel      byte-lane enables, o_wdata lane-replicated store data
//   o_rdata    extracted and extended load data, o_misalign alignment fault
module mem_lane_steer
  import mem_stage_ws_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]      i_adr_lo,
  input  size_t           i_size,
  input  logic            i_sign,
  input  logic [DW-1:0]   i_wdata,
  input  logic [DW-1:0]   i_rdata,
  output logic [DW/8-1:0] o_sel,
  output logic [DW-1:0]   o_wdata,
  output logic [DW-1:0]   o_rdata,
  output logic            o_misalign
);
  localparam int SELW = DW / 8;
  localparam int OW   = $clog2(SELW);

  logic [OW-1:0]   w_off;
  logic [3:0]      w_nbytes;
  logic [3:0]      w_shift;
  logic [SELW-1:0] w_mask;
  logic [DW-1:0]   w_raw;

  assign w_off = i_adr_lo[OW-1:0];

  // Size decode: lane count, lane mask, replication and alignment check.
  always_comb begin
    w_nbytes   = 4'd4;
    w_mask     = SELW'(4'hF);
    o_wdata    = {(DW/32){i_wdata[31:0]}};
    o_misalign = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        w_nbytes   = 4'd1;
        w_mask     = SELW'(1'b1);
        o_wdata    = {SELW{i_wdata[7:0]}};
        o_misalign = 1'b0;
      end
      SZ_HALF: begin
        w_nbytes   = 4'd2;
        w_mask     = SELW'(2'b11);
        o_wdata    = {(SELW/2){i_wdata[15:0]}};
        o_misalign = i_adr_lo[0];
      end
      SZ_WORD: begin
        w_nbytes   = 4'd4;
        w_mask     = SELW'(4'hF);
        o_wdata    = {(DW/32){i_wdata[31:0]}};
        o_misalign = (i_adr_lo[1:0] != 2'b00);
      end
      SZ_DWORD: begin
        w_nbytes   = 4'd8;
        w_mask     = {SELW{1'b1}};
        o_wdata    = i_wdata;
        // a doubleword only exists on a 64-bit bus
        o_misalign = (DW != 64) || (i_adr_lo != 3'b000);
      end
      default: begin
        w_nbytes   = 4'd4;
        w_mask     = SELW'(4'hF);
        o_wdata    = {(DW/32){i_wdata[31:0]}};
        o_misalign = 1'b1;
      end
    endcase
  end

  // Big-endian: byte offset o lives in lane SELW-1-o, so the access sits
  // (SELW - o - nbytes) lanes above lane 0. Faulting accesses use no lanes.
  always_comb begin
    if (o_misalign) begin
      w_shift = 4'd0;
      o_sel   = {SELW{1'b0}};
    end else begin
      w_shift = 4'(SELW) - 4'(w_off) - w_nbytes;
      o_sel   = w_mask << w_shift;
    end
  end

  assign w_raw = i_rdata >> {w_shift, 3'b000};

  // Right-aligned load data, sign- or zero-extended to the bus width.
  always_comb begin
    case (i_size)
      SZ_BYTE:  o_rdata = i_sign ? {{(DW-8){w_raw[7]}}, w_raw[7:0]}
                                 : DW'(w_raw[7:0]);
      SZ_HALF:  o_rdata = i_sign ? {{(DW-16){w_raw[15]}}, w_raw[15:0]}
                                 : DW'(w_raw[15:0]);
      SZ_WORD:  o_rdata = DW'(w_raw[31:0]);
      SZ_DWORD: o_rdata = w_raw;
      default:  o_rdata = w_raw;
    endcase
  end

endmodule

// File: rtl/mem_stage_ws.sv
// mem_stage_ws: pipelined memory-access stage between execute and writeback.
//   clk_i, rst_i (sync, active-high)
//   ir_i/pc_i/reg_write_i/result_i/reg_data1_i/ccr_i/halt_i  from execute
//   stall_i downstream stall, stall_o stall to upstream
//   ir_o/pc_o/ccr_o/reg_write_o/result_o/halt_o/exc_o       to writeback
//   bus   data-bus master port (mem_stage_ws_if.master)
module mem_stage_ws
  import mem_stage_ws_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int IRW  = 64,
  parameter int TO_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [IRW-1:0]  ir_i,
  input  logic [31:0]     pc_i,
  input  logic [1:0]      reg_write_i,
  input  logic [AW-1:0]   result_i,
  input  logic [DW-1:0]   reg_data1_i,
  input  logic [2:0]      ccr_i,
  input  logic            halt_i,
  input  logic            stall_i,
  output logic            stall_o,
  output logic [IRW-1:0]  ir_o,
  output logic [31:0]     pc_o,
  output logic [2:0]      ccr_o,
  output logic [1:0]      reg_write_o,
  output logic [DW-1:0]   result_o,
  output logic            halt_o,
  output logic [3:0]      exc_o,
  mem_stage_ws_if.master  bus
);
  localparam int SELW = DW / 8;
  // the counter reaches its all-ones maximum on the edge leaving this value
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [TO_W-1:0] CNT_ONE = {{(TO_W-1){1'b0}}, 1'b1};

  mem_state_t      r_state;
  logic [TO_W-1:0] r_cnt;
  logic            r_cyc;
  logic            r_we;
  logic [AW-1:0]   r_adr;
  logic [SELW-1:0] r_sel;
  logic [DW-1:0]   r_wdata;
  size_t           r_size;
  logic            r_sign;
  logic            r_is_load;
  logic [DW-1:0]   r_ldata;
  logic [3:0]      r_exc;
  logic [IRW-1:0]  r_ir;
  logic [31:0]     r_pc;
  logic [2:0]      r_ccr;
  logic [1:0]      r_reg_write;
  logic [DW-1:0]   r_result;
  logic            r_halt;
  logic [3:0]      r_exc_o;

  logic [3:0]      w_type;
  logic [3:0]      w_op;
  logic            w_mem_op;
  size_t           w_size;
  logic [2:0]      w_lane_adr;
  size_t           w_lane_size;
  logic            w_lane_sign;
  logic [SELW-1:0] w_sel;
  logic [DW-1:0]   w_wdata;
  logic [DW-1:0]   w_rdata;
  logic            w_misalign;
  logic            w_timeout;

  assign w_type    = ir_i[31:28];
  assign w_op      = ir_i[27:24];
  assign w_mem_op  = is_mem_op(w_type);
  assign w_size    = size_t'(w_op[1:0]);
  assign w_timeout = (r_cnt == TO_LAST);

  // Steering follows the incoming instruction in IDLE and the latched access afterwards.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_lane_adr  = result_i[2:0];
      w_lane_size = w_size;
      w_lane_sign = w_op[2];
    end else begin
      w_lane_adr  = r_adr[2:0];
      w_lane_size = r_size;
      w_lane_sign = r_sign;
    end
  end

  mem_lane_steer #(.DW(DW)) u_lane (
    .i_adr_lo   (w_lane_adr),
    .i_size     (w_lane_size),
    .i_sign     (w_lane_sign),
    .i_wdata    (reg_data1_i),
    .i_rdata    (bus.bus_in),
    .o_sel      (w_sel),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata),
    .o_misalign (w_misalign)
  );

  assign stall_o = stall_i
                 | ((r_state == ST_IDLE) & w_mem_op & ~w_misalign)
                 | (r_state == ST_BUS)
                 | ((r_state == ST_DONE) & stall_i);

  // Access state machine, bus master registers and pipeline register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {TO_W{1'b0}};
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= {AW{1'b0}};
      r_sel       <= {SELW{1'b0}};
      r_wdata     <= {DW{1'b0}};
      r_size      <= SZ_WORD;
      r_sign      <= 1'b0;
      r_is_load   <= 1'b0;
      r_ldata     <= {DW{1'b0}};
      r_exc       <= EXC_NONE;
      r_ir        <= {IRW{1'b0}};
      r_pc        <= 32'h0000_0000;
      r_ccr       <= 3'b000;
      r_reg_write <= 2'b00;
      r_result    <= {DW{1'b0}};
      r_halt      <= 1'b0;
      r_exc_o     <= EXC_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= {TO_W{1'b0}};
          if (w_mem_op && !w_misalign) begin
            // start the access even under a downstream stall
            r_adr     <= result_i;
            r_sel     <= w_sel;
            r_wdata   <= w_wdata;
            r_we      <= (w_type == T_STORE);
            r_is_load <= (w_type == T_LOAD);
            r_size    <= w_size;
            r_sign    <= w_op[2];
            r_ldata   <= {DW{1'b0}};
            r_exc     <= EXC_NONE;
            r_cyc     <= 1'b1;
            r_state   <= ST_BUS;
            if (!stall_i) begin
              r_ir        <= {IRW{1'b0}};
              r_reg_write <= 2'b00;
              r_halt      <= 1'b0;
              r_exc_o     <= EXC_NONE;
            end
          end else if (!stall_i) begin
            r_ir     <= ir_i;
            r_pc     <= pc_i;
            r_ccr    <= ccr_i;
            r_halt   <= halt_i;
            r_result <= DW'(result_i);
            if (w_mem_op) begin
              r_reg_write <= 2'b00;
              r_exc_o     <= EXC_ALIGN;
            end else begin
              r_reg_write <= reg_write_i;
              r_exc_o     <= EXC_NONE;
            end
          end
        end
        ST_BUS: begin
          r_cnt <= r_cnt + CNT_ONE;
          // error beats a simultaneous acknowledge
          if (bus.bus_err || w_timeout) begin
            r_exc   <= EXC_BUS;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= ST_DONE;
          end else if (bus.bus_ack) begin
            r_ldata <= w_rdata;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= ST_DONE;
          end
          if (!stall_i) begin
            r_ir        <= {IRW{1'b0}};
            r_reg_write <= 2'b00;
            r_halt      <= 1'b0;
            r_exc_o     <= EXC_NONE;
          end
        end
        ST_DONE: begin
          // upstream still holds the instruction, so retire it from the inputs
          if (!stall_i) begin
            r_ir        <= ir_i;
            r_pc        <= pc_i;
            r_ccr       <= ccr_i;
            r_halt      <= halt_i;
            r_result    <= r_is_load ? r_ldata : DW'(result_i);
            r_reg_write <= (r_exc != EXC_NONE) ? 2'b00 : reg_write_i;
            r_exc_o     <= r_exc;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cyc   <= 1'b0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bus_adr = r_adr;
  assign bus.bus_cyc = r_cyc;
  assign bus.bus_stb = r_cyc;
  assign bus.bus_we  = r_we;
  assign bus.bus_sel = r_sel;
  assign bus.bus_out = r_wdata;

  assign ir_o        = r_ir;
  assign pc_o        = r_pc;
  assign ccr_o       = r_ccr;
  assign reg_write_o = r_reg_write;
  assign result_o    = r_result;
  assign halt_o      = r_halt;
  assign exc_o       = r_exc_o;

endmodule

// File: tb/tb_mem_stage_ws.sv
// tb_mem_stage_ws: directed self-checking bench for mem_stage_ws (DW = 32).
module tb_mem_stage_ws;

  logic        clk;
  logic        rst_i;
  logic [63:0] ir_i;
  logic [31:0] pc_i;
  logic [1:0]  reg_write_i;
  logic [31:0] result_i;
  logic [31:0] reg_data1_i;
  logic [2:0]  ccr_i;
  logic        halt_i;
  logic        stall_i;
  logic        stall_o;
  logic [63:0] ir_o;
  logic [31:0] pc_o;
  logic [2:0]  ccr_o;
  logic [1:0]  reg_write_o;
  logic [31:0] result_o;
  logic        halt_o;
  logic [3:0]  exc_o;

  mem_stage_ws_if #(.AW(32), .DW(32)) bus_if ();

  mem_stage_ws #(.DW(32), .AW(32), .IRW(64), .TO_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .ir_i        (ir_i),
    .pc_i        (pc_i),
    .reg_write_i (reg_write_i),
    .result_i    (result_i),
    .reg_data1_i (reg_data1_i),
    .ccr_i       (ccr_i),
    .halt_i      (halt_i),
    .stall_i     (stall_i),
    .stall_o     (stall_o),
    .ir_o        (ir_o),
    .pc_o        (pc_o),
    .ccr_o       (ccr_o),
    .reg_write_o (reg_write_o),
    .result_o    (result_o),
    .halt_o      (halt_o),
    .exc_o       (exc_o),
    .bus         (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_fail;
  int          n_stall;
  int          n_cyc;
  logic        acc_done;
  logic [3:0]  cap_sel;
  logic        cap_we;
  logic [31:0] cap_out;
  logic [31:0] cap_adr;
  logic [63:0] cap_ir;

  localparam logic [63:0] IR_ALU  = 64'h0000_0000_0A00_0001; // type 0
  localparam logic [63:0] IR_LBS  = 64'h0000_0000_8600_0002; // load byte signed
  localparam logic [63:0] IR_LBU  = 64'h0000_0000_8200_0003; // load byte unsigned
  localparam logic [63:0] IR_LHS  = 64'h0000_0000_8500_0004; // load half signed
  localparam logic [63:0] IR_SH   = 64'h0000_0000_9100_0005; // store half
  localparam logic [63:0] IR_LW   = 64'h0000_0000_8000_0006; // load word

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [63:0] ir, input logic [31:0] pc, input logic [31:0] res,
                        input logic [1:0] rw, input logic [31:0] d1);
    ir_i        = ir;
    pc_i        = pc;
    result_i    = res;
    reg_write_i = rw;
    reg_data1_i = d1;
  endtask

  // Runs one access from IDLE until DONE, answering after 'waits' BUS cycles.
  task automatic do_access(input int waits, input logic use_ack, input logic use_err,
                           input int limit);
    logic seen;
    seen     = 1'b0;
    acc_done = 1'b0;
    n_stall  = 0;
    n_cyc    = 0;
    for (int c = 0; c < limit; c++) begin
      #1;
      if (bus_if.bus_cyc) begin
        if (!seen) begin
          cap_sel = bus_if.bus_sel;
          cap_we  = bus_if.bus_we;
          cap_out = bus_if.bus_out;
          cap_adr = bus_if.bus_adr;
          cap_ir  = ir_o;
        end
        seen           = 1'b1;
        bus_if.bus_ack = use_ack && (n_cyc == waits);
        bus_if.bus_err = use_err && (n_cyc == waits);
        n_cyc++;
      end else begin
        bus_if.bus_ack = 1'b0;
        bus_if.bus_err = 1'b0;
        if (seen) begin
          acc_done = 1'b1;
          break;
        end
      end
      if (stall_o) n_stall++;
      tick();
    end
    bus_if.bus_ack = 1'b0;
    bus_if.bus_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_i  = 1'b1;
    stall_i = 1'b0;
    ccr_i  = 3'b101;
    halt_i = 1'b0;
    set_in(64'h0, 32'h0, 32'h0, 2'b00, 32'h0);
    bus_if.bus_in  = 32'h0;
    bus_if.bus_ack = 1'b0;
    bus_if.bus_err = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_ir", ir_o, 64'h0);
    chk("rst_result", {32'h0, result_o}, 64'h0);
    chk("rst_exc", {60'h0, exc_o}, 64'h0);
    chk("rst_cyc", {63'h0, bus_if.bus_cyc}, 64'h0);
    rst_i = 1'b0;

    // non-memory pass-through
    set_in(IR_ALU, 32'h0000_0100, 32'h0000_1234, 2'b01, 32'h0);
    #1;
    chk("alu_stall", {63'h0, stall_o}, 64'h0);
    tick();
    chk("alu_result", {32'h0, result_o}, 64'h1234);
    chk("alu_ir", ir_o, IR_ALU);
    chk("alu_rw", {62'h0, reg_write_o}, 64'h1);
    chk("alu_ccr", {61'h0, ccr_o}, 64'h5);

    // signed byte load, two wait states
    set_in(IR_LBS, 32'h0000_0104, 32'h0000_0102, 2'b01, 32'h0);
    bus_if.bus_in = 32'h1122_8033;
    do_access(2, 1'b1, 1'b0, 20);
    chk("lbs_done", {63'h0, acc_done}, 64'h1);
    chk("lbs_sel", {60'h0, cap_sel}, 64'h2);
    chk("lbs_adr", {32'h0, cap_adr}, 64'h102);
    chk("lbs_bubble", cap_ir, 64'h0);
    chk("lbs_stall_cycles", 64'(n_stall), 64'd4);
    tick();
    chk("lbs_result", {32'h0, result_o}, 64'hFFFF_FF80);
    chk("lbs_ir", ir_o, IR_LBS);
    chk("lbs_exc", {60'h0, exc_o}, 64'h0);

    // unsigned byte load, one wait state
    set_in(IR_LBU, 32'h0000_0108, 32'h0000_0102, 2'b01, 32'h0);
    do_access(1, 1'b1, 1'b0, 20);
    tick();
    chk("lbu_result", {32'h0, result_o}, 64'h0000_0080);

    // signed half load at offset 2, zero wait states
    set_in(IR_LHS, 32'h0000_010C, 32'h0000_0102, 2'b10, 32'h0);
    do_access(0, 1'b1, 1'b0, 20);
    chk("lhs_sel", {60'h0, cap_sel}, 64'h3);
    chk("lhs_stall_cycles", 64'(n_stall), 64'd2);
    tick();
    chk("lhs_result", {32'h0, result_o}, 64'hFFFF_8033);
    chk("lhs_rw", {62'h0, reg_write_o}, 64'h2);

    // half store
    set_in(IR_SH, 32'h0000_0110, 32'h0000_0200, 2'b00, 32'h0000_BEEF);
    do_access(1, 1'b1, 1'b0, 20);
    chk("sh_we", {63'h0, cap_we}, 64'h1);
    chk("sh_sel", {60'h0, cap_sel}, 64'hC);
    chk("sh_out", {32'h0, cap_out}, 64'hBEEF_BEEF);
    chk("sh_cyc_len", 64'(n_cyc), 64'd2);
    tick();
    chk("sh_result", {32'h0, result_o}, 64'h200);
    chk("sh_we_after", {63'h0, bus_if.bus_we}, 64'h0);

    // misaligned word load
    set_in(IR_LW, 32'h0000_0114, 32'h0000_0003, 2'b01, 32'h0);
    #1;
    chk("mis_stall", {63'h0, stall_o}, 64'h0);
    tick();
    chk("mis_cyc", {63'h0, bus_if.bus_cyc}, 64'h0);
    chk("mis_exc", {60'h0, exc_o}, 64'h1);
    chk("mis_rw", {62'h0, reg_write_o}, 64'h0);
    chk("mis_ir", ir_o, IR_LW);

    // bus timeout
    set_in(IR_LW, 32'h0000_0118, 32'h0000_0400, 2'b01, 32'h0);
    do_access(0, 1'b0, 1'b0, 400);
    chk("to_done", {63'h0, acc_done}, 64'h1);
    chk("to_cyc_len", 64'(n_cyc), 64'd255);
    tick();
    chk("to_exc", {60'h0, exc_o}, 64'h2);
    chk("to_rw", {62'h0, reg_write_o}, 64'h0);

    // error together with ack
    set_in(IR_LW, 32'h0000_011C, 32'h0000_0500, 2'b01, 32'h0);
    bus_if.bus_in = 32'h1234_5678;
    do_access(0, 1'b1, 1'b1, 20);
    tick();
    chk("err_exc", {60'h0, exc_o}, 64'h2);
    chk("err_result", {32'h0, result_o}, 64'h0);
    chk("err_rw", {62'h0, reg_write_o}, 64'h0);

    // ack under downstream stall, retire after three stalled cycles
    set_in(IR_LW, 32'h0000_0120, 32'h0000_0300, 2'b01, 32'h0);
    bus_if.bus_in = 32'hCAFE_F00D;
    tick();
    chk("st_cyc", {63'h0, bus_if.bus_cyc}, 64'h1);
    bus_if.bus_ack = 1'b1;
    stall_i = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    #1;
    chk("st_done_cyc", {63'h0, bus_if.bus_cyc}, 64'h0);
    chk("st_done_stall", {63'h0, stall_o}, 64'h1);
    tick();
    chk("st_hold_cyc", {63'h0, bus_if.bus_cyc}, 64'h0);
    chk("st_hold_ir", ir_o, 64'h0);
    stall_i = 1'b0;
    #1;
    chk("st_release", {63'h0, stall_o}, 64'h0);
    tick();
    chk("st_result", {32'h0, result_o}, 64'hCAFE_F00D);
    chk("st_ir", ir_o, IR_LW);
    set_in(IR_ALU, 32'h0000_0124, 32'h0000_0055, 2'b01, 32'h0);
    tick();
    chk("st_no_rebus", {63'h0, bus_if.bus_cyc}, 64'h0);
    chk("st_next", {32'h0, result_o}, 64'h55);

    // reset during BUS
    set_in(IR_LW, 32'h0000_0128, 32'h0000_0600, 2'b01, 32'h0);
    tick();
    chk("rb_cyc", {63'h0, bus_if.bus_cyc}, 64'h1);
    rst_i = 1'b1;
    tick();
    chk("rb_cyc_off", {63'h0, bus_if.bus_cyc}, 64'h0);
    chk("rb_pc", {32'h0, pc_o}, 64'h0);
    chk("rb_result", {32'h0, result_o}, 64'h0);
    chk("rb_ccr", {61'h0, ccr_o}, 64'h0);
    rst_i = 1'b0;
    set_in(64'h0, 32'h0, 32'h0, 2'b00, 32'h0);
    bus_if.bus_ack = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    chk("late_ack_cyc", {63'h0, bus_if.bus_cyc}, 64'h0);
    chk("late_ack_exc", {60'h0, exc_o}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
